// File: rtl/vpu_reduction_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// vpu_reduction_sequencer_pkg
//   Shared types and defaults for the VPU reduction sequencer: operand and
//   chunk geometry, the exec-request op struct seen by the reduction unit,
//   the sequencer state encoding and the default chunk timeout.
// ----------------------------------------------------------------------------
package vpu_reduction_sequencer_pkg;

    localparam int unsigned OPERAND_WIDTH   = 16;   // bf16 scalar
    localparam int unsigned LANES_PER_EXEC  = 16;
    localparam int unsigned DWIDTH_PER_EXEC = OPERAND_WIDTH * LANES_PER_EXEC;
    localparam int unsigned VPU_EXEC_CNT    = 2;    // chunks per full vector
    localparam int unsigned RED_SEQ_TIMEOUT = 256;  // cycles per chunk before error

    typedef struct packed {
        logic fp_sum_r;
        logic fp_max_r;
    } vpu_fp_req_t;

    typedef struct packed {
        vpu_fp_req_t fp_req;
    } vpu_exec_req_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_ISSUE,
        RS_WAIT,
        RS_RESP
    } red_seq_state_t;

    // Exactly one of sum/max must be requested.
    function automatic logic red_op_legal(input vpu_exec_req_t op);
        return op.fp_req.fp_sum_r ^ op.fp_req.fp_max_r;
    endfunction

endpackage

// File: rtl/vpu_reduction_sequencer.sv
// ----------------------------------------------------------------------------
// vpu_reduction_sequencer
//   Runs one full-dimension FP_SUM / FP_MAX reduction through the reduction
//   unit: accepts op + EXEC_CNT chunks, issues one start per chunk while
//   holding the op stable, and returns the lane-0 scalar of the last chunk.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   req_*          request handshake: valid/ready, op, full operand vector
//   red_start_o    one-cycle start pulse per chunk to the reduction unit
//   red_op_o       op held from accept until response handshake, 0 in IDLE
//   red_operand_o  current chunk
//   red_dout_i     unit result (lane 0 used), red_done_i per-chunk done
//   rsp_*          response handshake: valid/ready, scalar data, error flag
//   busy_o         sequencer not idle
// ----------------------------------------------------------------------------
module vpu_reduction_sequencer
    import vpu_reduction_sequencer_pkg::*;
#(
    parameter int unsigned EXEC_CNT       = VPU_EXEC_CNT,
    parameter int unsigned TIMEOUT_CYCLES = RED_SEQ_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  vpu_exec_req_t                       req_op_i,
    input  logic [EXEC_CNT*DWIDTH_PER_EXEC-1:0] req_data_i,
    output logic                                red_start_o,
    output vpu_exec_req_t                       red_op_o,
    output logic [DWIDTH_PER_EXEC-1:0]          red_operand_o,
    input  logic [DWIDTH_PER_EXEC-1:0]          red_dout_i,
    input  logic                                red_done_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [OPERAND_WIDTH-1:0]            rsp_data_o,
    output logic                                rsp_err_o,
    output logic                                busy_o
);

    localparam int unsigned CNT_W = $clog2(EXEC_CNT);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CNT - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    red_seq_state_t                       r_state,    w_state;
    logic [CNT_W-1:0]                     r_cnt,      w_cnt;
    logic [TMR_W-1:0]                     r_timer,    w_timer;
    vpu_exec_req_t                        r_op,       w_op;
    logic [EXEC_CNT*DWIDTH_PER_EXEC-1:0]  r_data,     w_data;
    logic [OPERAND_WIDTH-1:0]             r_rsp_data, w_rsp_data;
    logic                                 r_err,      w_err;

    logic                                 w_active;
    logic                                 w_unused_dout;

    // Only lane 0 of the unit result carries the reduced scalar.
    assign w_unused_dout = ^red_dout_i[DWIDTH_PER_EXEC-1:OPERAND_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RS_IDLE;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_op       <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_timer    <= w_timer;
            r_op       <= w_op;
            r_data     <= w_data;
            r_rsp_data <= w_rsp_data;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_timer    = r_timer;
        w_op       = r_op;
        w_data     = r_data;
        w_rsp_data = r_rsp_data;
        w_err      = r_err;
        case (r_state)
            RS_IDLE: begin
                if (req_valid_i) begin
                    w_op   = req_op_i;
                    w_data = req_data_i;
                    w_cnt  = '0;
                    if (red_op_legal(req_op_i)) begin
                        w_state = RS_ISSUE;
                    end else begin
                        // Illegal op: answer straight away, the unit never starts.
                        w_state    = RS_RESP;
                        w_err      = 1'b1;
                        w_rsp_data = '0;
                    end
                end
            end
            RS_ISSUE: begin
                w_timer = '0;
                w_state = RS_WAIT;
            end
            RS_WAIT: begin
                if (red_done_i) begin
                    if (r_cnt == CNT_LAST) begin
                        w_rsp_data = red_dout_i[OPERAND_WIDTH-1:0];
                        w_err      = 1'b0;
                        w_state    = RS_RESP;
                    end else begin
                        w_cnt   = r_cnt + 1'b1;
                        w_state = RS_ISSUE;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_err      = 1'b1;
                    w_rsp_data = '0;
                    w_state    = RS_RESP;
                end else if (r_timer != '1) begin
                    w_timer = r_timer + 1'b1;
                end
            end
            RS_RESP: begin
                if (rsp_ready_i) begin
                    w_state    = RS_IDLE;
                    w_cnt      = '0;
                    w_err      = 1'b0;
                    w_rsp_data = '0;
                    w_op       = '0;
                end
            end
            default: w_state = RS_IDLE;
        endcase
    end

    assign w_active      = (r_state == RS_ISSUE) || (r_state == RS_WAIT);
    assign req_ready_o   = (r_state == RS_IDLE);
    assign busy_o        = (r_state != RS_IDLE);
    assign red_start_o   = (r_state == RS_ISSUE);
    assign red_op_o      = busy_o ? r_op : '0;
    assign red_operand_o = w_active ? r_data[r_cnt*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] : '0;
    assign rsp_valid_o   = (r_state == RS_RESP);
    assign rsp_data_o    = rsp_valid_o ? r_rsp_data : '0;
    assign rsp_err_o     = rsp_valid_o & r_err;

endmodule

// File: tb/tb_vpu_reduction_sequencer.sv
module tb_vpu_reduction_sequencer;
    import vpu_reduction_sequencer_pkg::*;

    localparam int EXEC = 2;
    localparam int DW   = 256;
    localparam int OW   = 16;
    localparam int TO   = 8;

    localparam vpu_exec_req_t OP_SUM  = 2'b10;
    localparam vpu_exec_req_t OP_MAX  = 2'b01;
    localparam vpu_exec_req_t OP_BOTH = 2'b11;
    localparam vpu_exec_req_t OP_NONE = 2'b00;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready_o;
    vpu_exec_req_t        req_op;
    logic [EXEC*DW-1:0]   req_data;
    logic                 red_start_o;
    vpu_exec_req_t        red_op_o;
    logic [DW-1:0]        red_operand_o;
    logic                 rsp_valid_o;
    logic                 rsp_ready;
    logic [OW-1:0]        rsp_data_o;
    logic                 rsp_err_o;
    logic                 busy_o;

    logic                 m_done;
    logic [DW-1:0]        m_dout;
    int                   m_cd;
    int                   m_nchunk;
    real                  m_acc;
    bit                   m_done_en;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vpu_reduction_sequencer #(.EXEC_CNT(EXEC), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op),
        .req_data_i    (req_data),
        .red_start_o   (red_start_o),
        .red_op_o      (red_op_o),
        .red_operand_o (red_operand_o),
        .red_dout_i    (m_dout),
        .red_done_i    (m_done),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data_o),
        .rsp_err_o     (rsp_err_o),
        .busy_o        (busy_o)
    );

    // ---------------- bf16 helpers (normal numbers only) ----------------
    function automatic real bf2r(input logic [15:0] b);
        real r;
        int  e;
        e = int'(b[14:7]);
        if (e == 0) return 0.0;
        r = 1.0 + real'(b[6:0]) / 128.0;
        for (int i = 0; i < e - 127; i++) r = r * 2.0;
        for (int i = 0; i < 127 - e; i++) r = r / 2.0;
        return b[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        real        a;
        int         e;
        int         m;
        logic [7:0] e8;
        logic [6:0] m7;
        if (r == 0.0) return 16'h0000;
        a = (r < 0.0) ? -r : r;
        e = 127;
        for (int i = 0; i < 200 && a >= 2.0; i++) begin a = a / 2.0; e++; end
        for (int i = 0; i < 200 && a < 1.0; i++) begin a = a * 2.0; e--; end
        m  = int'($floor((a - 1.0) * 128.0));
        e8 = e[7:0];
        m7 = m[6:0];
        return {(r < 0.0), e8, m7};
    endfunction

    function automatic real fold(input real acc0, input logic [DW-1:0] ch, input bit is_max);
        real a;
        real x;
        a = acc0;
        for (int l = 0; l < DW / OW; l++) begin
            x = bf2r(ch[l*OW +: OW]);
            if (is_max) a = (x > a) ? x : a;
            else        a = a + x;
        end
        return a;
    endfunction

    // Behavioural reduction unit: accumulates across the chunks of one job,
    // done pulses 3 cycles after the start cycle, result in lane 0.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done   <= 1'b0;
            m_dout   <= '0;
            m_cd     <= 0;
            m_nchunk <= 0;
            m_acc    <= 0.0;
        end else begin
            m_done <= 1'b0;
            if (red_start_o) begin
                m_acc    <= fold((m_nchunk == 0) ? (red_op_o.fp_req.fp_max_r ? -1.0e30 : 0.0) : m_acc,
                                 red_operand_o, red_op_o.fp_req.fp_max_r);
                m_dout   <= {{15{16'hDEAD}},
                             r2bf(fold((m_nchunk == 0) ? (red_op_o.fp_req.fp_max_r ? -1.0e30 : 0.0) : m_acc,
                                       red_operand_o, red_op_o.fp_req.fp_max_r))};
                m_nchunk <= (m_nchunk + 1) % EXEC;
                m_cd     <= 2;
            end else if (m_cd != 0) begin
                m_cd <= m_cd - 1;
                if (m_cd == 1 && m_done_en) m_done <= 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o,   1);
        chk({tag, "_red_start"}, red_start_o,   0);
        chk({tag, "_red_op"},    red_op_o,      0);
        chk({tag, "_operand"},   red_operand_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o,   0);
        chk({tag, "_rsp_data"},  rsp_data_o,    0);
        chk({tag, "_rsp_err"},   rsp_err_o,     0);
        chk({tag, "_busy"},      busy_o,        0);
    endtask

    function automatic logic [EXEC*DW-1:0] build(input logic [15:0] fill, input int idx, input logic [15:0] val);
        logic [EXEC*DW-1:0] d;
        for (int i = 0; i < EXEC * DW / OW; i++) d[i*OW +: OW] = (i == idx) ? val : fill;
        return d;
    endfunction

    typedef struct {
        string         name;
        vpu_exec_req_t op;
        logic [15:0]   fill;
        int            sp_idx;
        logic [15:0]   sp_val;
        logic [15:0]   exp_data;
        logic          exp_err;
        int            exp_starts;
    } vec_t;

    // Caller is at a negedge with the DUT idle; returns at a negedge, idle.
    task automatic run_job(input vec_t v, input int hold);
        logic [EXEC*DW-1:0] d;
        logic [OW-1:0]      d0;
        logic               e0;
        int                 starts;
        int                 k;
        bit                 op_ok;
        bit                 hold_ok;
        d = build(v.fill, v.sp_idx, v.sp_val);
        req_op    = v.op;
        req_data  = d;
        req_valid = 1'b1;
        chk({v.name, "_req_ready"}, req_ready_o, 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = OP_NONE;
        starts = 0;
        k      = 0;
        op_ok  = 1'b1;
        while (!rsp_valid_o && k < 200) begin
            if (red_op_o !== v.op) op_ok = 1'b0;
            if (red_start_o) begin
                if (starts < EXEC) chk({v.name, "_operand"}, red_operand_o, d[starts*DW +: DW]);
                starts++;
            end
            @(negedge clk);
            k++;
        end
        chk({v.name, "_rsp_valid"}, rsp_valid_o, 1);
        chk({v.name, "_latency"},   k, v.exp_err ? 0 : EXEC * 4);
        chk({v.name, "_starts"},    starts, v.exp_starts);
        chk({v.name, "_op_held"},   op_ok, 1);
        chk({v.name, "_rsp_data"},  rsp_data_o, v.exp_data);
        chk({v.name, "_rsp_err"},   rsp_err_o, v.exp_err);
        d0      = rsp_data_o;
        e0      = rsp_err_o;
        hold_ok = 1'b1;
        // Offer a competing request while the response is back-pressured.
        if (hold > 0) begin
            req_valid = 1'b1;
            req_op    = OP_SUM;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid_o || rsp_data_o !== d0 || rsp_err_o !== e0 || req_ready_o !== 1'b0 ||
                red_op_o !== v.op || red_start_o)
                hold_ok = 1'b0;
        end
        req_valid = 1'b0;
        req_op    = OP_NONE;
        if (hold > 0) chk({v.name, "_hold_stable"}, hold_ok, 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({v.name, "_idle_after"}, {rsp_valid_o, req_ready_o, busy_o}, 3'b010);
    endtask

    vec_t vecs[7];

    initial begin
        int k;
        vec_t v;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_NONE;
        req_data  = '0;
        rsp_ready = 1'b0;
        m_done_en = 1'b1;

        vecs[0] = '{"sum_ones",   OP_SUM,  16'h3F80, -1, 16'h0000, 16'h4200, 1'b0, 2};
        vecs[1] = '{"max_e20",    OP_MAX,  16'h3F80, 20, 16'h4120, 16'h4120, 1'b0, 2};
        vecs[2] = '{"sum_twos",   OP_SUM,  16'h4000, -1, 16'h0000, 16'h4280, 1'b0, 2};
        vecs[3] = '{"max_e3",     OP_MAX,  16'h3F80,  3, 16'h4040, 16'h4040, 1'b0, 2};
        vecs[4] = '{"sum_neg31",  OP_SUM,  16'h3F80, 31, 16'hBF80, 16'h41F0, 1'b0, 2};
        vecs[5] = '{"op_both",    OP_BOTH, 16'h3F80, -1, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[6] = '{"op_none",    OP_NONE, 16'h3F80, -1, 16'h0000, 16'h0000, 1'b1, 0};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_job(vecs[i], 0);

        // Back-pressure: response held for 5 cycles, next job accepted right after.
        run_job(vecs[0], 5);
        run_job(vecs[1], 0);

        // Timeout: unit never answers; start taken at the next edge, RESP 8 edges later.
        m_done_en = 1'b0;
        req_op    = OP_SUM;
        req_data  = build(16'h3F80, -1, 16'h0000);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("timeout_start", red_start_o, 1);
        k = 0;
        while (!rsp_valid_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_latency", k, 1 + TO);
        chk("timeout_err",     rsp_err_o, 1);
        chk("timeout_data",    rsp_data_o, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        m_done_en = 1'b1;
        chk("timeout_idle", {rsp_valid_o, req_ready_o, busy_o}, 3'b010);

        // Reset while waiting on chunk 1; unit model is reset alongside.
        req_op    = OP_SUM;
        req_data  = build(16'h3F80, -1, 16'h0000);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!(red_start_o && red_operand_o === req_data[DW +: DW]) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rst_chunk1_start", red_start_o, 1);
        @(negedge clk);
        chk("rst_in_wait", {busy_o, red_start_o}, 2'b10);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v = vecs[0];
        v.name = "sum_after_rst";
        run_job(v, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
